// File: rtl/lcd_spi_arbiter_if.sv
// Requester / spi_master bundle shared between the LCD drawing engines and the arbiter.
// The arbiter connects through the slave modport; the drawing side uses master.
interface lcd_spi_arbiter_if #(
   parameter int unsigned NREQ = 4
);
   logic [NREQ-1:0]   req;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_dc;
   logic [NREQ-1:0]   req_last;
   logic [NREQ-1:0]   grant;
   logic [NREQ-1:0]   ack;
   logic              aborted;
   logic              busy;
   logic [7:0]        spi_data;
   logic              spi_dc;
   logic              spi_start;
   logic              spi_avail;

   modport master (
      output req, req_data, req_dc, req_last, spi_avail,
      input  grant, ack, aborted, busy, spi_data, spi_dc, spi_start
   );

   modport slave (
      input  req, req_data, req_dc, req_last, spi_avail,
      output grant, ack, aborted, busy, spi_data, spi_dc, spi_start
   );
endinterface

// File: rtl/lcd_spi_arbiter.sv
// Round-robin arbiter sharing one PCD8544 spi_master between several burst requesters;
// a grant is held for a whole burst so cursor-positioned writes never interleave.
module lcd_spi_arbiter #(
   parameter int unsigned NREQ       = 4,
   parameter int unsigned GAP_CYCLES = 4
) (
   input logic              clock,
   input logic              reset,
   lcd_spi_arbiter_if.slave bus
);
   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, BURST, DRAIN, GAP} state_e;

   state_e          state_q;
   logic [PW-1:0]   ptr_q;
   logic [PW-1:0]   gidx_q;
   logic [NREQ-1:0] grant_q;
   logic            start_q;
   logic            aborted_q;
   logic [7:0]      hold_data_q;
   logic            hold_dc_q;
   logic [7:0]      gap_q;

   logic            win_vld;
   logic [PW-1:0]   win_idx;
   logic [NREQ-1:0] win_oh;
   logic [PW-1:0]   scan_idx;
   logic [PW-1:0]   ptr_d;
   logic [7:0]      cur_data;
   logic            cur_dc;
   logic            cur_last;
   logic            cur_req;
   logic [7:0]      spi_data_mux;
   logic            spi_dc_mux;

   // First requesting index scanning ptr, ptr+1, ... modulo NREQ.
   always_comb begin
      win_vld  = 1'b0;
      win_idx  = '0;
      win_oh   = '0;
      scan_idx = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         scan_idx = PW'((32'(ptr_q) + k) % NREQ);
         if (!win_vld && bus.req[scan_idx]) begin
            win_vld          = 1'b1;
            win_idx          = scan_idx;
            win_oh           = '0;
            win_oh[scan_idx] = 1'b1;
         end
      end
   end

   assign ptr_d    = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
   assign cur_data = bus.req_data[{gidx_q, 3'b000} +: 8];
   assign cur_dc   = bus.req_dc[gidx_q];
   assign cur_last = bus.req_last[gidx_q];
   assign cur_req  = bus.req[gidx_q];

   always_comb begin
      spi_data_mux = '0;
      spi_dc_mux   = 1'b0;
      if (state_q == BURST) begin
         spi_data_mux = cur_data;
         spi_dc_mux   = cur_dc;
      end else if (state_q == DRAIN) begin
         spi_data_mux = hold_data_q;
         spi_dc_mux   = hold_dc_q;
      end
   end

   assign bus.grant     = grant_q;
   assign bus.ack       = (state_q == BURST && bus.spi_avail) ? grant_q : '0;
   assign bus.aborted   = aborted_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.spi_data  = spi_data_mux;
   assign bus.spi_dc    = spi_dc_mux;
   assign bus.spi_start = start_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         gidx_q      <= '0;
         grant_q     <= '0;
         start_q     <= 1'b0;
         aborted_q   <= 1'b0;
         hold_data_q <= '0;
         hold_dc_q   <= 1'b0;
         gap_q       <= '0;
      end else begin
         aborted_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (win_vld) begin
                  grant_q <= win_oh;
                  gidx_q  <= win_idx;
                  start_q <= 1'b1;
                  state_q <= BURST;
               end
            end
            BURST: begin
               // A last byte taken together with a req drop still ends the burst normally.
               if (bus.spi_avail) begin
                  if (cur_last) begin
                     grant_q <= '0;
                     start_q <= 1'b0;
                     ptr_q   <= ptr_d;
                     gap_q   <= '0;
                     state_q <= GAP;
                  end
               end else if (!cur_req) begin
                  hold_data_q <= cur_data;
                  hold_dc_q   <= cur_dc;
                  state_q     <= DRAIN;
               end
            end
            DRAIN: begin
               if (bus.spi_avail) begin
                  grant_q   <= '0;
                  start_q   <= 1'b0;
                  aborted_q <= 1'b1;
                  ptr_q     <= ptr_d;
                  gap_q     <= '0;
                  state_q   <= GAP;
               end
            end
            GAP: begin
               if (gap_q == 8'(GAP_CYCLES - 1)) begin
                  gap_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  gap_q <= gap_q + 8'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lcd_spi_arbiter.sv
// Scoreboard bench: requesters and a fixed-latency spi_master model drive the arbiter,
// expected bytes / grants / aborts are queued at issue time and checked by a monitor.
module tb_lcd_spi_arbiter;
   localparam int NREQ = 4;
   localparam int GAP  = 4;
   localparam int LAT  = 3;

   typedef struct packed { logic [7:0] d; logic dc; logic last; } rbyte_t;
   typedef struct packed { int idx; logic [7:0] d; logic dc; bit acked; } ebyte_t;
   typedef struct packed { logic [3:0] oh; int gap; } egrant_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lcd_spi_arbiter_if #(.NREQ(NREQ)) bus ();

   lcd_spi_arbiter #(.NREQ(NREQ), .GAP_CYCLES(GAP)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   rbyte_t  rq [NREQ][$];
   ebyte_t  exp_byte[$];
   egrant_t exp_grant[$];
   int      exp_abort[$];

   bit   drop[NREQ];
   int   ackcnt[NREQ];
   int   abort_after[NREQ];
   int   abort_seen = 0;
   logic [3:0] ack_seen = '0;
   logic start_s = 1'b0;
   int   cnt = 0;
   int   n_cmp = 0;
   int   n_fail = 0;
   logic [3:0] prev_grant = '0;
   int   low_cnt = 0;
   int   idle_wait = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit pending();
      for (int i = 0; i < NREQ; i++)
         if (rq[i].size() != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drive_reqs();
      for (int i = 0; i < NREQ; i++) begin
         if (rq[i].size() != 0) begin
            bus.req[i]             = !drop[i];
            bus.req_data[8*i +: 8] = rq[i][0].d;
            bus.req_dc[i]          = rq[i][0].dc;
            bus.req_last[i]        = rq[i][0].last;
         end else begin
            bus.req[i]             = 1'b0;
            bus.req_data[8*i +: 8] = 8'h00;
            bus.req_dc[i]          = 1'b0;
            bus.req_last[i]        = 1'b0;
         end
      end
   endtask

   // mode: 0 = byte never reaches the SPI, 1 = consumed with ack, 2 = consumed by drain
   task automatic add_byte(input int idx, input logic [7:0] d, input logic dc,
                           input logic last, input int mode);
      rbyte_t r;
      ebyte_t e;
      r.d = d; r.dc = dc; r.last = last;
      rq[idx].push_back(r);
      if (mode != 0) begin
         e.idx = idx; e.d = d; e.dc = dc; e.acked = (mode == 1);
         exp_byte.push_back(e);
      end
   endtask

   task automatic add_grant(input logic [3:0] oh, input int gap);
      egrant_t g;
      g.oh = oh; g.gap = gap;
      exp_grant.push_back(g);
   endtask

   task automatic sync();
      @(posedge clk);
      #2;
   endtask

   // kind: 0 idle, 1 ack count of idx >= val, 2 grant[idx] high, 3 abort count >= val
   task automatic wait_for(input int kind, input int idx, input int val, input string nm);
      int c;
      bit done;
      c = 0;
      done = 1'b0;
      forever begin
         case (kind)
            0:       done = !bus.busy && !pending();
            1:       done = (ackcnt[idx] >= val);
            2:       done = bus.grant[idx];
            default: done = (abort_seen >= val);
         endcase
         if (done || c >= 2000) break;
         sync();
         c++;
      end
      if (!done) begin
         n_cmp++;
         n_fail++;
         $display("FAIL timeout_%s: got no event expected event within 2000 cycles", nm);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_grant"}, 32'(bus.grant), 0);
      check({tag, "_ack"}, 32'(bus.ack), 0);
      check({tag, "_aborted"}, 32'(bus.aborted), 0);
      check({tag, "_busy"}, 32'(bus.busy), 0);
      check({tag, "_spi_start"}, 32'(bus.spi_start), 0);
      check({tag, "_spi_data"}, 32'(bus.spi_data), 0);
      check({tag, "_spi_dc"}, 32'(bus.spi_dc), 0);
   endtask

   // Requesters and spi_master model: act just after each rising edge.
   always @(posedge clk) begin
      #1;
      if (rst) begin
         bus.spi_avail = 1'b0;
         cnt = 0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (ack_seen[i] && rq[i].size() != 0) begin
               void'(rq[i].pop_front());
               ackcnt[i]++;
               if (ackcnt[i] == abort_after[i]) drop[i] = 1'b1;
            end
         end
         if (bus.spi_avail) begin
            bus.spi_avail = 1'b0;
            cnt = 0;
         end else if (start_s) begin
            if (cnt == LAT - 1) begin
               bus.spi_avail = 1'b1;
               cnt = 0;
            end else begin
               cnt++;
            end
         end else begin
            cnt = 0;
         end
      end
      drive_reqs();
   end

   // Monitor: samples on the falling edge.
   always @(negedge clk) begin
      ebyte_t  e;
      egrant_t g;
      logic [3:0] oh;
      ack_seen = bus.ack;
      start_s  = bus.spi_start;
      if (rst) begin
         prev_grant = '0;
         idle_wait  = 0;
      end else begin
         if (bus.spi_avail && bus.spi_start) begin
            if (exp_byte.size() == 0) begin
               check("byte_unexpected", 32'(bus.spi_data), 32'hFFFF_FFFF);
            end else begin
               e  = exp_byte.pop_front();
               oh = 4'b0001 << e.idx;
               check("spi_data", 32'(bus.spi_data), 32'(e.d));
               check("spi_dc", 32'(bus.spi_dc), 32'(e.dc));
               check("byte_grant", 32'(bus.grant), 32'(oh));
               check("byte_ack", 32'(bus.ack), e.acked ? 32'(oh) : 0);
            end
         end else begin
            check("ack_stray", 32'(bus.ack), 0);
         end
         check("start_vs_grant", 32'(bus.spi_start), 32'(bus.grant != 0));
         if (bus.aborted) begin
            abort_seen++;
            if (exp_abort.size() == 0) check("abort_unexpected", 1, 0);
            else void'(exp_abort.pop_front());
         end
         if (prev_grant == 0 && bus.grant != 0) begin
            if (exp_grant.size() == 0) begin
               check("grant_unexpected", 32'(bus.grant), 0);
            end else begin
               g = exp_grant.pop_front();
               check("grant_order", 32'(bus.grant), 32'(g.oh));
               if (g.gap >= 0) check("start_low_gap", low_cnt, g.gap);
            end
            check("grant_latency", idle_wait, 1);
            idle_wait = 0;
            low_cnt   = 0;
         end else if (!bus.busy && bus.req != 0) begin
            idle_wait++;
         end
         if (!bus.spi_start) low_cnt++;
         prev_grant = bus.grant;
      end
   end

   initial begin
      int a0;
      bus.req = '0; bus.req_data = '0; bus.req_dc = '0; bus.req_last = '0; bus.spi_avail = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         drop[i] = 1'b0; ackcnt[i] = 0; abort_after[i] = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst");
      #1 rst = 1'b0;

      // Round robin with all four requesting: 0,1,2,3 then 0 again.
      sync();
      add_grant(4'b0001, -1); add_grant(4'b0010, GAP + 1); add_grant(4'b0100, GAP + 1);
      add_grant(4'b1000, GAP + 1); add_grant(4'b0001, GAP + 1);
      add_byte(0, 8'h11, 1'b1, 1'b1, 1);
      add_byte(1, 8'h22, 1'b0, 1'b1, 1);
      add_byte(2, 8'h33, 1'b1, 1'b1, 1);
      add_byte(3, 8'h44, 1'b0, 1'b1, 1);
      add_byte(0, 8'h55, 1'b1, 1'b1, 1);
      wait_for(0, 0, 0, "rr");

      // Single requester 2, three bytes.
      sync();
      add_grant(4'b0100, -1);
      add_byte(2, 8'h80, 1'b0, 1'b0, 1);
      add_byte(2, 8'h40, 1'b0, 1'b0, 1);
      add_byte(2, 8'hFF, 1'b1, 1'b1, 1);
      wait_for(0, 0, 0, "single");

      // Requester 1 arrives mid-burst of requester 0 and must wait for the burst plus gap.
      sync();
      ackcnt[0] = 0;
      add_grant(4'b0001, -1); add_grant(4'b0010, GAP + 1);
      for (int b = 1; b <= 5; b++)
         add_byte(0, 8'(b), 1'(b % 2), 1'(b == 5), 1);
      wait_for(1, 0, 2, "contend_ack");
      add_byte(1, 8'hA5, 1'b1, 1'b1, 1);
      wait_for(0, 0, 0, "contend");

      // Requester 3 drops req after its first byte: drained byte, one abort, ptr wraps to 0.
      sync();
      ackcnt[3] = 0;
      abort_after[3] = 1;
      a0 = abort_seen;
      add_grant(4'b1000, -1);
      add_byte(3, 8'hC1, 1'b0, 1'b0, 1);
      add_byte(3, 8'hC2, 1'b1, 1'b0, 2);
      add_byte(3, 8'hC3, 1'b1, 1'b1, 0);
      exp_abort.push_back(1);
      wait_for(3, 0, a0 + 1, "abort");
      rq[3].delete();
      drop[3] = 1'b0;
      abort_after[3] = 0;
      wait_for(0, 0, 0, "abort_idle");
      sync();
      add_grant(4'b0001, -1); add_grant(4'b1000, GAP + 1);
      add_byte(0, 8'hD0, 1'b0, 1'b1, 1);
      add_byte(3, 8'hD3, 1'b1, 1'b1, 1);
      wait_for(0, 0, 0, "after_abort");

      // Pointer wrap: after granting 3, req = 1100 goes to 2 first.
      sync();
      add_grant(4'b1000, -1);
      add_byte(3, 8'hE1, 1'b0, 1'b1, 1);
      wait_for(2, 3, 0, "wrap_grant3");
      add_grant(4'b0100, GAP + 1); add_grant(4'b1000, GAP + 1);
      add_byte(2, 8'hE2, 1'b1, 1'b1, 1);
      add_byte(3, 8'hE3, 1'b0, 1'b1, 1);
      wait_for(0, 0, 0, "wrap");

      // Reset during byte 2 of 4, then requester 1 is served normally.
      sync();
      ackcnt[2] = 0;
      add_grant(4'b0100, -1);
      add_byte(2, 8'hF1, 1'b0, 1'b0, 1);
      add_byte(2, 8'hF2, 1'b1, 1'b0, 0);
      add_byte(2, 8'hF3, 1'b1, 1'b0, 0);
      add_byte(2, 8'hF4, 1'b1, 1'b1, 0);
      wait_for(1, 2, 1, "rst_burst_ack");
      rst = 1'b1;
      rq[2].delete();
      drive_reqs();
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("midrst");
      #1 rst = 1'b0;
      sync();
      add_grant(4'b0010, -1);
      add_byte(1, 8'h5A, 1'b1, 1'b1, 1);
      wait_for(0, 0, 0, "post_reset");

      repeat (3) @(posedge clk);
      check("left_bytes", exp_byte.size(), 0);
      check("left_grants", exp_grant.size(), 0);
      check("left_aborts", exp_abort.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
